// File: rtl/dsram_resp_if.sv
// Data-memory port bundle between the CPU (master) and the SRAM responder (slave).
// Split request/response handshake: req/addr_ok accept a request, and data_ok returns its result.
interface dsram_resp_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/dsram_resp.sv
// dsram_resp: data-side SRAM responder with an in-order outstanding queue.
// Accepted requests are answered after a fixed latency.
// Head-of-queue responses are presented through registered data_ok, rdata and err.
// Optional macro DSRAM_RESP_STALL_EN adds LFSR-driven random backpressure on addr_ok.
module dsram_resp #(
    parameter int AW          = 10,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    dsram_resp_if.slave  bus
);
    localparam int CW = 3;
    localparam int TW = 3;

    logic [31:0]    mem_q [2**AW];

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    ent_rdata_q [OUTSTANDING];
    logic [31:0]    ent_rdata_d [OUTSTANDING];
    logic           ent_err_q   [OUTSTANDING];
    logic           ent_err_d   [OUTSTANDING];
    logic [TW-1:0]  ent_tmr_q   [OUTSTANDING];
    logic [TW-1:0]  ent_tmr_d   [OUTSTANDING];

    logic [31:0]    sh_rdata [OUTSTANDING];
    logic           sh_err   [OUTSTANDING];
    logic [TW-1:0]  sh_tmr   [OUTSTANDING];

    logic           out_ok_q, out_ok_d;
    logic [31:0]    out_rdata_q, out_rdata_d;
    logic           out_err_q, out_err_d;

    logic [AW-1:0]  word_idx;
    logic           misaligned;
    logic           retire;
    logic           stall_ok;
    logic           push;
    logic           mem_we;
    logic [31:0]    rd_word;
    logic [CW-1:0]  cnt_pop;

    assign word_idx   = bus.addr[AW+1:2];
    assign misaligned = ((bus.size == 2'd1) && bus.addr[0]) ||
                        (bus.size[1] && (bus.addr[1:0] != 2'b00));

    // The head retires while its timer sits at zero; this is exactly when data_ok is high.
    assign retire = (cnt_q != '0) && (ent_tmr_q[0] == '0);

`ifdef DSRAM_RESP_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR with taps 8,6,5,4 for pseudo-random acceptance stalls.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR state register, seeded to a fixed non-zero value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end

    assign stall_ok = (lfsr_q[1:0] != 2'b00);
`else
    assign stall_ok = 1'b1;
`endif

    // addr_ok depends only on reset, the queue state and the stall source; it never depends on req.
    assign bus.addr_ok = reset && stall_ok && ((cnt_q < CW'(OUTSTANDING)) || retire);
    assign push        = bus.req && bus.addr_ok;
    assign mem_we      = push && bus.wr && !misaligned;
    assign rd_word     = mem_q[word_idx];

    // Source for each slot when the head pops; the tail slot empties.
    for (genvar gi = 0; gi < OUTSTANDING; gi++) begin : g_shift
        if (gi < OUTSTANDING - 1) begin : g_mid
            assign sh_rdata[gi] = ent_rdata_q[gi+1];
            assign sh_err[gi]   = ent_err_q[gi+1];
            assign sh_tmr[gi]   = ent_tmr_q[gi+1];
        end else begin : g_last
            assign sh_rdata[gi] = '0;
            assign sh_err[gi]   = 1'b0;
            assign sh_tmr[gi]   = '0;
        end
    end

    // Queue next state: pop the head, age all timers, then append any accepted request.
    always_comb begin
        cnt_pop = cnt_q - CW'(retire);
        for (int i = 0; i < OUTSTANDING; i++) begin
            ent_rdata_d[i] = retire ? sh_rdata[i] : ent_rdata_q[i];
            ent_err_d[i]   = retire ? sh_err[i]   : ent_err_q[i];
            ent_tmr_d[i]   = retire ? sh_tmr[i]   : ent_tmr_q[i];
            if (ent_tmr_d[i] != '0) begin
                ent_tmr_d[i] = ent_tmr_d[i] - TW'(1);
            end
            if (push && (cnt_pop == CW'(i))) begin
                // The acceptance edge counts as the first timer decrement.
                ent_tmr_d[i]   = TW'(LATENCY - 1);
                ent_err_d[i]   = misaligned;
                ent_rdata_d[i] = (bus.wr || misaligned) ? 32'h0 : rd_word;
            end
        end
        cnt_d       = cnt_pop + CW'(push);
        out_ok_d    = (cnt_d != '0) && (ent_tmr_d[0] == '0);
        out_rdata_d = out_ok_d ? ent_rdata_d[0] : 32'h0;
        out_err_d   = out_ok_d && ent_err_d[0];
    end

    // Queue and response registers; reset drops every outstanding entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            out_ok_q    <= 1'b0;
            out_rdata_q <= 32'h0;
            out_err_q   <= 1'b0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                ent_rdata_q[i] <= 32'h0;
                ent_err_q[i]   <= 1'b0;
                ent_tmr_q[i]   <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            out_ok_q    <= out_ok_d;
            out_rdata_q <= out_rdata_d;
            out_err_q   <= out_err_d;
            for (int i = 0; i < OUTSTANDING; i++) begin
                ent_rdata_q[i] <= ent_rdata_d[i];
                ent_err_q[i]   <= ent_err_d[i];
                ent_tmr_q[i]   <= ent_tmr_d[i];
            end
        end
    end

    // Byte-lane store into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem_q[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    assign bus.data_ok = out_ok_q;
    assign bus.rdata   = out_rdata_q;
    assign bus.err     = out_err_q;
endmodule

// File: tb/tb_dsram_resp.sv
// Testbench for dsram_resp.
// Applies table-driven single transactions, then runs streaming, backpressure and mid-operation reset sequences.
module tb_dsram_resp;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dsram_resp_if bus ();
    dsram_resp_if bus1 ();

    dsram_resp #(.AW(10), .LATENCY(LAT), .OUTSTANDING(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    dsram_resp #(.AW(10), .LATENCY(LAT), .OUTSTANDING(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Precondition: called just after a rising edge. Returns just after a rising edge.
    task automatic do_txn(input string name, input vec_t v, output int waits);
        int lat, pulses;
        logic [31:0] got_rdata;
        logic        got_err;
        bus.req   = 1'b1;
        bus.wr    = v.wr;
        bus.size  = v.size;
        bus.wstrb = v.wstrb;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        waits = 0;
        @(negedge clk);
        while (!bus.addr_ok && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.addr_ok) begin
            chk({name, " accept"}, {31'b0, bus.addr_ok}, 32'd1);
            bus.req = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        lat = 0;
        pulses = 0;
        got_rdata = 32'h0;
        got_err = 1'b0;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk);
            if (bus.data_ok) begin
                if (pulses == 0) begin
                    lat = k;
                    got_rdata = bus.rdata;
                    got_err = bus.err;
                end
                pulses++;
            end
        end
        $display("txn %s wr=%0d size=%0d addr=%h rdata=%h err=%0d lat=%0d", name, v.wr, v.size,
                 v.addr, got_rdata, got_err, lat);
        chk({name, " latency"}, lat, LAT);
        chk({name, " pulses"}, pulses, 1);
        chk({name, " rdata"}, got_rdata, v.exp_rdata);
        chk({name, " err"}, {31'b0, got_err}, {31'b0, v.exp_err});
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[18];

    initial begin
        int waits;
        int resp_n, first_c, last_c;
        logic [31:0] exp_stream;
        vec_t v;

        vecs[0]  = '{1'b1, 2'd2, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 2'd2, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 4'b0100, 32'h0000_0010, 32'h00AA_0000, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 2'd2, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAA_BEEF, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 4'h0,    32'h0000_0012, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{1'b0, 2'd1, 4'h0,    32'h0000_0013, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b1, 2'd2, 4'hF,    32'h0000_0012, 32'h1234_5678, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 2'd2, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAA_BEEF, 1'b0};
        vecs[8]  = '{1'b0, 2'd2, 4'h0,    32'h0000_1010, 32'h0,         32'hDEAA_BEEF, 1'b0};
        vecs[9]  = '{1'b1, 2'd2, 4'hF,    32'h0000_0020, 32'h1122_3344, 32'h0,         1'b0};
        vecs[10] = '{1'b1, 2'd2, 4'h0,    32'h0000_0020, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 2'd2, 4'h0,    32'h0000_0020, 32'h0,         32'h1122_3344, 1'b0};
        vecs[12] = '{1'b1, 2'd1, 4'b1100, 32'h0000_0022, 32'hABCD_0000, 32'h0,         1'b0};
        vecs[13] = '{1'b0, 2'd2, 4'h0,    32'h0000_0020, 32'h0,         32'hABCD_3344, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 4'h0,    32'h0000_0023, 32'h0,         32'hABCD_3344, 1'b0};
        vecs[15] = '{1'b0, 2'd3, 4'h0,    32'h0000_0021, 32'h0,         32'h0,         1'b1};
        vecs[16] = '{1'b0, 2'd1, 4'h0,    32'h0000_0012, 32'h0,         32'hDEAA_BEEF, 1'b0};
        vecs[17] = '{1'b0, 2'd2, 4'h0,    32'hFFFF_F020, 32'h0,         32'hABCD_3344, 1'b0};

        bus.req = 1'b1;  bus.wr = 1'b0;  bus.size = 2'd2;  bus.wstrb = 4'h0;
        bus.addr = 32'h0;  bus.wdata = 32'h0;
        bus1.req = 1'b0; bus1.wr = 1'b0; bus1.size = 2'd2; bus1.wstrb = 4'h0;
        bus1.addr = 32'h0; bus1.wdata = 32'h0;

        // Reset state, with req asserted so that any req to addr_ok path shows up.
        repeat (3) @(negedge clk);
        chk("reset addr_ok", {31'b0, bus.addr_ok}, 32'd0);
        chk("reset data_ok", {31'b0, bus.data_ok}, 32'd0);
        chk("reset rdata", bus.rdata, 32'h0);
        chk("reset err", {31'b0, bus.err}, 32'd0);
        bus.req = 1'b0;

        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (vecs[i]) begin
            do_txn($sformatf("vec%0d", i), vecs[i], waits);
        end

        // Eight back-to-back loads with req held high; OUTSTANDING=1 copy alternates addr_ok.
        resp_n = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 8 + LAT + 4; c++) begin
            if (c < 8) begin
                bus.req  = 1'b1; bus.wr = 1'b0; bus.size = 2'd2;
                bus.addr = c[0] ? 32'h20 : 32'h10;
                bus1.req = 1'b1; bus1.addr = 32'h40;
            end else begin
                bus.req  = 1'b0;
                bus1.req = 1'b0;
            end
            @(negedge clk);
            if (c < 8) begin
                chk($sformatf("stream addr_ok c%0d", c), {31'b0, bus.addr_ok}, 32'd1);
                chk($sformatf("os1 addr_ok c%0d", c), {31'b0, bus1.addr_ok},
                    (c % 2 == 0) ? 32'd1 : 32'd0);
            end
            if (bus.data_ok) begin
                exp_stream = resp_n[0] ? 32'hABCD_3344 : 32'hDEAA_BEEF;
                $display("txn stream resp%0d rdata=%h", resp_n, bus.rdata);
                chk($sformatf("stream rdata%0d", resp_n), bus.rdata, exp_stream);
                if (first_c < 0) first_c = c;
                last_c = c;
                resp_n++;
            end
            @(posedge clk);
            #1;
        end
        chk("stream count", resp_n, 8);
        chk("stream back-to-back", last_c - first_c, 7);

        // Two loads outstanding, then reset pulled low.
        bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = 32'h10;
        @(negedge clk);
        chk("pre-reset accept0", {31'b0, bus.addr_ok}, 32'd1);
        @(posedge clk);
        #1;
        bus.addr = 32'h20;
        @(negedge clk);
        chk("pre-reset accept1", {31'b0, bus.addr_ok}, 32'd1);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid-reset data_ok", {31'b0, bus.data_ok}, 32'd0);
        chk("mid-reset addr_ok", {31'b0, bus.addr_ok}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("in-reset data_ok c%0d", c), {31'b0, bus.data_ok}, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        v = '{1'b0, 2'd2, 4'h0, 32'h0000_0020, 32'h0, 32'hABCD_3344, 1'b0};
        do_txn("post-reset", v, waits);
        chk("post-reset first-edge accept", waits, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
